axis_pipe_chain: RTL and testbench
==================================

# axis_pipe_chain

Parametrised AXI-Stream register chain: STAGES cascaded skid-buffered register slices carrying tdata plus tlast/tuser sideband, with a selectable register mode. It is the next generation of the single-stage AXIS pipe, used to break long timing paths between stream blocks. It runs at full throughput, registers both directions in full mode, and reports how many beats it currently holds.

## Interface
- AXIS_WIDTH, 32, tdata width in bits (≥1)
- USER_WIDTH, 1, tuser width in bits (≥1)
- STAGES, 2, number of cascaded slices (1..16)
- REG_MODE, 2, 0 = bypass (wires), 1 = forward-only (valid/data registered, tready combinational), 2 = full (valid/data and tready registered, skid buffer)
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_axis_tvalid  input  1  upstream valid
- s_axis_tdata  input  AXIS_WIDTH  upstream data
- s_axis_tlast  input  1  upstream end of packet
- s_axis_tuser  input  USER_WIDTH  upstream sideband
- s_axis_tready  output  1  upstream ready
- m_axis_tvalid  output  1  downstream valid
- m_axis_tdata  output  AXIS_WIDTH  downstream data
- m_axis_tlast  output  1  downstream end of packet
- m_axis_tuser  output  USER_WIDTH  downstream sideband
- m_axis_tready  input  1  downstream ready
- occupancy  output  $clog2(2*STAGES+1)  beats held in the chain

## Operation
- Beat = {tuser, tlast, tdata}. Beats are carried as one bundle, never reordered, dropped or duplicated.
- Each slice follows AXIS rules:
  - Output valid/data are held stable while valid=1 and ready=0.
  - A transfer occurs when valid & ready are both high on a rising edge.
- Mode 2 slice:
  - Holds a main register plus one skid register.
  - Its s_ready is registered.
  - When the downstream stalls with the main register full and a beat is accepted in the same cycle, that beat goes to the skid register and s_ready drops next cycle.
  - When the main register drains, the skid beat moves to main and s_ready returns to 1.
- Mode 1 slice:
  - Main register only.
  - s_ready = ~m_valid | m_ready, combinational.
- Mode 0:
  - All m_* outputs equal the matching s_* inputs.
  - s_axis_tready = m_axis_tready.
  - occupancy = 0.
  - STAGES is ignored.
- occupancy = count of valid main registers plus valid skid registers across all slices. It is updated each cycle as accepted-in minus accepted-out.
- Reset values:
  - m_axis_tvalid = 0.
  - m_axis_tdata, m_axis_tlast, m_axis_tuser = 0.
  - occupancy = 0.
  - All internal valid bits = 0.
- s_axis_tready during and after reset:
  - Mode 2: 0 while reset is high; rises to 1 on the first clock edge after reset deasserts.
  - Mode 1: 1 when the chain is empty, including during reset.
- Reset mid-stream discards all held beats. Nothing already accepted is emitted after reset.

## Timing
- Latency when not stalled: mode 2 = STAGES cycles, mode 1 = STAGES cycles, mode 0 = 0 cycles.
- Throughput is one beat per cycle whenever m_axis_tready is continuously high, in every mode.
- Mode 2 capacity:
  - 2*STAGES beats.
  - After m_axis_tready falls, the chain accepts beats until full. s_axis_tready is then low.
  - When m_axis_tready rises, the first beat leaves that edge. s_axis_tready returns to 1 within STAGES cycles.
- Mode 1 capacity is STAGES beats. The upstream sees a stall in the same cycle as the downstream.
- Simultaneous accept and emit in the same cycle leaves occupancy unchanged.
- occupancy never exceeds 2*STAGES (mode 2) or STAGES (mode 1).
- m_axis_tvalid never depends combinationally on m_axis_tready.

## Structure
- Shared package axis_pkg holds:
  - REG_MODE constants AXIS_REG_BYPASS=0, AXIS_REG_FWD=1, AXIS_REG_FULL=2.
  - A helper function for beat width, AXIS_WIDTH+USER_WIDTH+1.
- Sub-module axis_reg_slice:
  - One slice over a packed beat vector of parameter WIDTH and MODE, exporting its own valid-count (0..2).
  - Instantiated STAGES times in a generate loop.
- Top level:
  - Packs and unpacks the beat.
  - Handles mode 0.
  - Sums the slice counts into occupancy, registered or accumulated incrementally.

## Test plan
- **Reset and streaming.** Mode 2, STAGES=2. Hold reset, release, then stream data 1..8 with m_axis_tready=1.
  - s_axis_tready=0 in reset and 1 the next cycle.
  - m_axis_tdata shows 1..8 on consecutive cycles, starting 2 cycles after the first accept.
  - tlast appears only on beat 8.
- **Fill and drain.** Mode 2, STAGES=3. m_axis_tready=0 while presenting beats 0xA0.. continuously.
  - Exactly 6 beats are accepted.
  - occupancy=6 and s_axis_tready=0.
  - After raising m_axis_tready, beats 0xA0..0xA5 emerge in order, one per cycle, and occupancy reaches 0.
- **Random stress.** Random tvalid/tready at 50%, each mode, STAGES=1 and 4, 10k beats.
  - The scoreboard shows the output sequence equals the input sequence, including tuser/tlast.
  - No valid/data change occurs while stalled.
- **Mode 0 pass-through.** Drive tdata=0x1234, tuser=1, tready toggling.
  - Outputs follow the inputs in the same cycle.
  - occupancy stays 0.
- **Reset mid-stream.** Mode 2, 4 beats held. Assert reset for 1 cycle.
  - m_axis_tvalid=0 and occupancy=0 after the edge.
  - None of the 4 beats is ever emitted.
- **Mode 1 stall propagation.** STAGES=2, chain full, m_axis_tready low.
  - s_axis_tready is low in that same cycle.
  - When m_axis_tready goes high, s_axis_tready goes high in that same cycle.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: shared constants and helpers for the AXI-Stream register chain.
// Holds register-mode encodings and the packed beat width helper.
package axis_pkg;

    localparam int AXIS_REG_BYPASS = 0;
    localparam int AXIS_REG_FWD    = 1;
    localparam int AXIS_REG_FULL   = 2;

    // Packed beat is {tuser, tlast, tdata}.
    function automatic int axis_beat_width(
        input int data_w,
        input int user_w
    );
        return data_w + user_w + 1;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: one valid/ready register slice over a packed beat vector.
// Ports: clk/reset (sync, active-high); s_* upstream valid/data/ready;
// m_* downstream valid/data/ready; count_o = beats held (0..2).
module axis_reg_slice
    import axis_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int MODE  = AXIS_REG_FULL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [1:0]       count_o
);

    if (MODE == AXIS_REG_FULL) begin : g_full
        logic             main_valid_q;
        logic             main_valid_d;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] main_d;
        logic             skid_valid_q;
        logic             skid_valid_d;
        logic [WIDTH-1:0] skid_q;
        logic [WIDTH-1:0] skid_d;
        logic             ready_q;
        logic             s_xfer;
        logic             m_xfer;

        assign s_xfer = s_valid_i & ready_q;
        assign m_xfer = main_valid_q & m_ready_i;

        // Main refills from skid first; ready_q is low whenever skid is
        // occupied, so an upstream beat never races the skid beat.
        always_comb begin
            main_valid_d = main_valid_q;
            main_d       = main_q;
            skid_valid_d = skid_valid_q;
            skid_d       = skid_q;
            if (!main_valid_q || m_xfer) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = s_xfer;
                    if (s_xfer) begin
                        main_d = s_data_i;
                    end
                end
            end else if (s_xfer) begin
                skid_valid_d = 1'b1;
                skid_d       = s_data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                main_valid_q <= 1'b0;
                main_q       <= '0;
                skid_valid_q <= 1'b0;
                skid_q       <= '0;
                ready_q      <= 1'b0;
            end else begin
                main_valid_q <= main_valid_d;
                main_q       <= main_d;
                skid_valid_q <= skid_valid_d;
                skid_q       <= skid_d;
                ready_q      <= ~skid_valid_d;
            end
        end

        assign s_ready_o = ready_q;
        assign m_valid_o = main_valid_q;
        assign m_data_o  = main_q;
        assign count_o   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    end else if (MODE == AXIS_REG_FWD) begin : g_fwd
        logic             main_valid_q;
        logic             main_valid_d;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] main_d;
        logic             ready;

        assign ready = ~main_valid_q | m_ready_i;

        always_comb begin
            main_valid_d = main_valid_q;
            main_d       = main_q;
            if (ready) begin
                main_valid_d = s_valid_i;
                if (s_valid_i) begin
                    main_d = s_data_i;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                main_valid_q <= 1'b0;
                main_q       <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                main_q       <= main_d;
            end
        end

        assign s_ready_o = ready;
        assign m_valid_o = main_valid_q;
        assign m_data_o  = main_q;
        assign count_o   = {1'b0, main_valid_q};

    end else begin : g_bypass
        assign s_ready_o = m_ready_i;
        assign m_valid_o = s_valid_i;
        assign m_data_o  = s_data_i;
        assign count_o   = 2'd0;
    end

endmodule

// File: rtl/axis_pipe_chain.sv
// axis_pipe_chain: STAGES cascaded AXI-Stream register slices with tlast/tuser.
// Ports: clk/reset (sync, active-high); s_axis_* upstream; m_axis_* downstream;
// occupancy = beats currently held across all slices.
module axis_pipe_chain
    import axis_pkg::*;
#(
    parameter int AXIS_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int STAGES     = 2,
    parameter int REG_MODE   = AXIS_REG_FULL
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_axis_tvalid,
    input  logic [AXIS_WIDTH-1:0]            s_axis_tdata,
    input  logic                             s_axis_tlast,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,
    output logic                             s_axis_tready,
    output logic                             m_axis_tvalid,
    output logic [AXIS_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    input  logic                             m_axis_tready,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int BW    = axis_beat_width(AXIS_WIDTH, USER_WIDTH);
    localparam int OCC_W = $clog2(2*STAGES+1);

    if (REG_MODE == AXIS_REG_BYPASS) begin : g_bypass
        assign m_axis_tvalid = s_axis_tvalid;
        assign m_axis_tdata  = s_axis_tdata;
        assign m_axis_tlast  = s_axis_tlast;
        assign m_axis_tuser  = s_axis_tuser;
        assign s_axis_tready = m_axis_tready;
        assign occupancy     = '0;

    end else begin : g_chain
        logic [BW-1:0]    beat  [STAGES+1];
        logic             valid [STAGES+1];
        logic             ready [STAGES+1];
        logic [1:0]       cnt   [STAGES];
        logic [OCC_W-1:0] occ_sum;

        assign beat[0]       = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
        assign valid[0]      = s_axis_tvalid;
        assign ready[STAGES] = m_axis_tready;

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            axis_reg_slice #(
                .WIDTH (BW),
                .MODE  (REG_MODE)
            ) u_slice (
                .clk       (clk),
                .reset     (reset),
                .s_valid_i (valid[i]),
                .s_data_i  (beat[i]),
                .s_ready_o (ready[i]),
                .m_valid_o (valid[i+1]),
                .m_data_o  (beat[i+1]),
                .m_ready_i (ready[i+1]),
                .count_o   (cnt[i])
            );
        end

        // Every term is a flop output, so occupancy is glitch-free state.
        always_comb begin
            occ_sum = '0;
            for (int i = 0; i < STAGES; i++) begin
                occ_sum = occ_sum + OCC_W'(cnt[i]);
            end
        end

        assign s_axis_tready = ready[0];
        assign m_axis_tvalid = valid[STAGES];
        assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = beat[STAGES];
        assign occupancy     = occ_sum;
    end

endmodule

// File: tb/tb_axis_pipe_chain.sv
// tb_axis_pipe_chain: directed and randomised checks of axis_pipe_chain
// across modes 0/1/2 and several STAGES values, all sharing one stimulus.
module tb_axis_pipe_chain;
    import axis_pkg::*;

    localparam int N   = 8;
    localparam int IA  = 0;
    localparam int IB  = 1;
    localparam int IC  = 2;
    localparam int ID  = 3;
    localparam int CYC = 30000;

    function automatic int stg_of(input int g);
        case (g)
            0: return 2;
            1: return 3;
            2: return 2;
            3: return 1;
            4: return 1;
            5: return 4;
            6: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int mode_of(input int g);
        case (g)
            0, 1, 4, 5: return AXIS_REG_FULL;
            2, 6, 7:    return AXIS_REG_FWD;
            default:    return AXIS_REG_BYPASS;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic [0:0]  s_user;
    logic        m_ready;

    logic        sr [N];
    logic        mv [N];
    logic        ml [N];
    logic        mu [N];
    logic [31:0] md [N];
    logic [4:0]  oc [N];

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] sb [N][64];
    int          wp [N];
    int          rp [N];
    logic        stall_q [N];
    logic [33:0] hold_q  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int S = stg_of(g);
        localparam int M = mode_of(g);
        logic [$clog2(2*S+1)-1:0] occ;
        logic        rdy;
        logic        vld;
        logic        lst;
        logic [31:0] dat;
        logic [0:0]  usr;

        axis_pipe_chain #(
            .AXIS_WIDTH (32),
            .USER_WIDTH (1),
            .STAGES     (S),
            .REG_MODE   (M)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .s_axis_tvalid (s_valid),
            .s_axis_tdata  (s_data),
            .s_axis_tlast  (s_last),
            .s_axis_tuser  (s_user),
            .s_axis_tready (rdy),
            .m_axis_tvalid (vld),
            .m_axis_tdata  (dat),
            .m_axis_tlast  (lst),
            .m_axis_tuser  (usr),
            .m_axis_tready (m_ready),
            .occupancy     (occ)
        );

        assign sr[g] = rdy;
        assign mv[g] = vld;
        assign ml[g] = lst;
        assign mu[g] = usr[0];
        assign md[g] = dat;
        assign oc[g] = 5'(occ);
    end

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sr[IA] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_sready_m2: got %b want 0", sr[IA]);
        end
        n_vec++;
        if (sr[IC] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_sready_m1: got %b want 1", sr[IC]);
        end
        n_vec++;
        if (mv[IA] !== 1'b0 || md[IA] !== 32'h0 || ml[IA] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mout: got v=%b d=%h l=%b want 0/0/0",
                     mv[IA], md[IA], ml[IA]);
        end
        n_vec++;
        if (oc[IA] !== 5'd0 || mv[IC] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_occ: got occ=%0d v1=%b want 0/0",
                     oc[IA], mv[IC]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (sr[IA] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_sready_hold: got %b want 0", sr[IA]);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sr[IA] !== 1'b1 || sr[IB] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_sready_rise: got %b/%b want 1/1",
                     sr[IA], sr[IB]);
        end
    endtask

    task automatic test_streaming();
        logic exp_v;
        m_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            s_valid = (t < 8);
            s_data  = 32'(t + 1);
            s_last  = (t == 7);
            s_user  = 1'b0;
            @(negedge clk);
            exp_v = (t >= 2 && t < 10);
            n_vec++;
            if (mv[IA] !== exp_v) begin
                n_err++;
                $display("FAIL stream_valid t=%0d: got %b want %b",
                         t, mv[IA], exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if (md[IA] !== 32'(t - 1) || ml[IA] !== (t == 9)) begin
                    n_err++;
                    $display("FAIL stream_data t=%0d: got %0d/%b want %0d/%b",
                             t, md[IA], ml[IA], t - 1, (t == 9));
                end
            end
            if (t < 8) begin
                n_vec++;
                if (sr[IA] !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_ready t=%0d: got %b want 1",
                             t, sr[IA]);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_fill_drain();
        int acc;
        do_reset();
        m_ready = 1'b0;
        acc     = 0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = 32'hA0 + 32'(acc);
            s_last  = 1'b0;
            @(negedge clk);
            if (sr[IB]) acc++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        n_vec++;
        if (acc != 6) begin
            n_err++;
            $display("FAIL fill_count: got %0d want 6", acc);
        end
        @(negedge clk);
        n_vec++;
        if (oc[IB] !== 5'd6 || sr[IB] !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: got occ=%0d rdy=%b want 6/0",
                     oc[IB], sr[IB]);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            n_vec++;
            if (j < 6) begin
                if (mv[IB] !== 1'b1 || md[IB] !== 32'hA0 + 32'(j) ||
                    oc[IB] !== 5'(6 - j)) begin
                    n_err++;
                    $display("FAIL drain j=%0d: got v=%b d=%h occ=%0d want 1/%h/%0d",
                             j, mv[IB], md[IB], oc[IB], 32'hA0 + 32'(j), 6 - j);
                end
            end else begin
                if (mv[IB] !== 1'b0 || oc[IB] !== 5'd0) begin
                    n_err++;
                    $display("FAIL drain_empty: got v=%b occ=%0d want 0/0",
                             mv[IB], oc[IB]);
                end
            end
            if (j == 3) begin
                n_vec++;
                if (sr[IB] !== 1'b1) begin
                    n_err++;
                    $display("FAIL drain_ready: got %b want 1", sr[IB]);
                end
            end
        end
    endtask

    task automatic test_mode0();
        s_data = 32'h1234;
        s_user = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            m_ready = (t % 2 == 1);
            s_valid = (t != 2);
            s_last  = (t == 3);
            #1;
            n_vec++;
            if (md[ID] !== 32'h1234 || mu[ID] !== 1'b1 ||
                mv[ID] !== s_valid || ml[ID] !== s_last ||
                sr[ID] !== m_ready || oc[ID] !== 5'd0) begin
                n_err++;
                $display("FAIL mode0 t=%0d: got d=%h u=%b v=%b l=%b r=%b o=%0d want 1234/1/%b/%b/%b/0",
                         t, md[ID], mu[ID], mv[ID], ml[ID], sr[ID], oc[ID],
                         s_valid, s_last, m_ready);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int acc;
        do_reset();
        m_ready = 1'b0;
        acc     = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            s_valid = (acc < 4);
            s_data  = 32'h50 + 32'(acc);
            @(negedge clk);
            if (s_valid && sr[IA]) acc++;
        end
        n_vec++;
        if (acc != 4 || oc[IA] !== 5'd4) begin
            n_err++;
            $display("FAIL mid_held: got acc=%0d occ=%0d want 4/4",
                     acc, oc[IA]);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mv[IA] !== 1'b0 || oc[IA] !== 5'd0 || md[IA] !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b occ=%0d d=%h want 0/0/0",
                     mv[IA], oc[IA], md[IA]);
        end
        m_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_vec++;
            if (mv[IA] !== 1'b0) begin
                n_err++;
                $display("FAIL mid_ghost t=%0d: got v=%b d=%h want v=0",
                         t, mv[IA], md[IA]);
            end
        end
    endtask

    task automatic test_mode1_stall();
        do_reset();
        m_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = 32'h70 + 32'(t);
        end
        @(negedge clk);
        n_vec++;
        if (oc[IC] !== 5'd2 || sr[IC] !== 1'b0 ||
            mv[IC] !== 1'b1 || md[IC] !== 32'h70) begin
            n_err++;
            $display("FAIL m1_full: got occ=%0d r=%b v=%b d=%h want 2/0/1/70",
                     oc[IC], sr[IC], mv[IC], md[IC]);
        end
        @(posedge clk); #1;
        n_vec++;
        if (sr[IC] !== 1'b0) begin
            n_err++;
            $display("FAIL m1_stall: got %b want 0", sr[IC]);
        end
        m_ready = 1'b1;
        #1;
        n_vec++;
        if (sr[IC] !== 1'b1) begin
            n_err++;
            $display("FAIL m1_release: got %b want 1", sr[IC]);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_random_stress();
        logic [33:0] ob;
        do_reset();
        for (int g = 0; g < N; g++) begin
            wp[g]      = 0;
            rp[g]      = 0;
            stall_q[g] = 1'b0;
            hold_q[g]  = '0;
        end
        for (int t = 0; t < CYC + 32; t++) begin
            @(posedge clk); #1;
            if (t < CYC) begin
                s_valid = 1'($urandom_range(0, 1));
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                s_valid = 1'b0;
                m_ready = 1'b1;
            end
            s_data = $urandom;
            s_last = 1'($urandom_range(0, 1));
            s_user = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                ob = {mu[g], ml[g], md[g]};
                n_vec++;
                if (oc[g] !== 5'(wp[g] - rp[g])) begin
                    n_err++;
                    $display("FAIL rnd_occ g=%0d t=%0d: got %0d want %0d",
                             g, t, oc[g], wp[g] - rp[g]);
                end
                if (stall_q[g] && mode_of(g) != AXIS_REG_BYPASS) begin
                    n_vec++;
                    if (mv[g] !== 1'b1 || ob !== hold_q[g]) begin
                        n_err++;
                        $display("FAIL rnd_hold g=%0d t=%0d: got %b/%h want 1/%h",
                                 g, t, mv[g], ob, hold_q[g]);
                    end
                end
                if (s_valid && sr[g]) begin
                    sb[g][wp[g] % 64] = {s_user, s_last, s_data};
                    wp[g]++;
                end
                if (mv[g] && m_ready) begin
                    n_vec++;
                    if (rp[g] == wp[g]) begin
                        n_err++;
                        $display("FAIL rnd_extra g=%0d t=%0d: got %h want none",
                                 g, t, ob);
                    end else begin
                        if (ob !== sb[g][rp[g] % 64]) begin
                            n_err++;
                            $display("FAIL rnd_data g=%0d t=%0d: got %h want %h",
                                     g, t, ob, sb[g][rp[g] % 64]);
                        end
                        rp[g]++;
                    end
                end
                stall_q[g] = mv[g] & ~m_ready;
                hold_q[g]  = ob;
            end
        end
        for (int g = 0; g < N; g++) begin
            n_vec++;
            if (wp[g] != rp[g] || wp[g] < 1000) begin
                n_err++;
                $display("FAIL rnd_drain g=%0d: got in=%0d out=%0d want equal",
                         g, wp[g], rp[g]);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_fill_drain();
        test_mode0();
        test_reset_midstream();
        test_mode1_stall();
        test_random_stress();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
